// File: rtl/regfile_sb_pkg.sv
// Shared constants and types for the scoreboarded register file.
// The default geometry lives here so that the top and the scoreboard agree on it.
package regfile_sb_pkg;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_NUM_REGS = 32;
    localparam int DEFAULT_ADDR_W   = $clog2(DEFAULT_NUM_REGS);

    // Lookup ports on the scoreboard: read port 1, read port 2, issuing destination.
    localparam int NUM_LOOKUP = 3;

    typedef logic [DEFAULT_ADDR_W-1:0] regidx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// One pending bit per architectural register: set on issue, cleared on writeback.
// When set and clear hit the same index in one cycle, set wins.
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_idx,
    input  logic [ADDR_W-1:0] lookup_idx  [NUM_LOOKUP],
    output logic              lookup_pend [NUM_LOOKUP]
);

    logic [NUM_REGS-1:0] r_pending;
    logic                w_set_ok;

    // Register 0 can never become pending when it is hard-wired to zero.
    assign w_set_ok = set_en && !((ZERO_REG != 0) && (set_idx == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            if (clr_en) begin
                r_pending[clr_idx] <= 1'b0;
            end
            if (w_set_ok) begin
                r_pending[set_idx] <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_LOOKUP; gi++) begin : g_lookup
        assign lookup_pend[gi] = r_pending[lookup_idx[gi]];
    end

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write-to-read forwarding and a
// pending-write scoreboard for RAW/WAW hazard detection.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              busy1,
    output logic              busy2,
    output logic              busy_rd
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_we_ok;
    logic [ADDR_W-1:0] w_lk_idx  [NUM_LOOKUP];
    logic              w_lk_pend [NUM_LOOKUP];
    logic [ADDR_W-1:0] w_raddr   [2];
    logic [DATA_W-1:0] w_rdata   [2];
    logic              w_busy    [2];

    assign w_we_ok = we && !((ZERO_REG != 0) && (waddr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we_ok) begin
            r_regs[waddr] <= wdata;
        end
    end

    assign w_lk_idx[0] = raddr1;
    assign w_lk_idx[1] = raddr2;
    assign w_lk_idx[2] = issue_rd;

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .set_en      (issue),
        .set_idx     (issue_rd),
        .clr_en      (we),
        .clr_idx     (waddr),
        .lookup_idx  (w_lk_idx),
        .lookup_pend (w_lk_pend)
    );

    assign w_raddr[0] = raddr1;
    assign w_raddr[1] = raddr2;

    // A forwarded read reports the pending state as it will be after this edge:
    // the writeback clears it unless a same-index issue re-sets it.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rport
        logic w_zero_hit;
        logic w_fwd;
        logic w_issue_hit;

        assign w_zero_hit  = (ZERO_REG != 0) && (w_raddr[gi] == '0);
        assign w_fwd       = (BYPASS != 0) && we && (waddr == w_raddr[gi]);
        assign w_issue_hit = issue && (issue_rd == w_raddr[gi]);

        assign w_rdata[gi] = w_zero_hit ? '0 :
                             w_fwd      ? wdata : r_regs[w_raddr[gi]];
        assign w_busy[gi]  = w_zero_hit ? 1'b0 :
                             w_fwd      ? w_issue_hit : w_lk_pend[gi];
    end

    assign rdata1  = w_rdata[0];
    assign rdata2  = w_rdata[1];
    assign busy1   = w_busy[0];
    assign busy2   = w_busy[1];
    assign busy_rd = w_lk_pend[2];

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed check of regfile_sb against an array-based model.
// Instance 0 uses defaults (bypass, zero reg); instance 1 has neither.
module tb_regfile_sb;
    import regfile_sb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    regidx_t     waddr = '0;
    logic [31:0] wdata = '0;
    regidx_t     raddr1 = '0;
    regidx_t     raddr2 = '0;
    logic        issue = 1'b0;
    regidx_t     issue_rd = '0;

    logic [31:0] rdata1_o [2];
    logic [31:0] rdata2_o [2];
    logic        busy1_o  [2];
    logic        busy2_o  [2];
    logic        busyrd_o [2];

    int n_total = 0;
    int n_bad   = 0;

    // Reference state per configuration.
    logic [31:0] m_regs [2][32];
    bit          m_pend [2][32];
    localparam bit CFG_BYPASS [2] = '{1'b1, 1'b0};
    localparam bit CFG_ZERO   [2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    regfile_sb u_dut_a (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_o[0]), .rdata2(rdata2_o[0]),
        .issue(issue), .issue_rd(issue_rd),
        .busy1(busy1_o[0]), .busy2(busy2_o[0]), .busy_rd(busyrd_o[0])
    );

    regfile_sb #(.BYPASS(0), .ZERO_REG(0)) u_dut_b (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_o[1]), .rdata2(rdata2_o[1]),
        .issue(issue), .issue_rd(issue_rd),
        .busy1(busy1_o[1]), .busy2(busy2_o[1]), .busy_rd(busyrd_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected read-port view of one configuration in the current cycle.
    function automatic void exp_read(input int c, input int a,
                                     output logic [31:0] d, output logic b);
        if (CFG_ZERO[c] && a == 0) begin
            d = 32'h0;
            b = 1'b0;
        end else if (CFG_BYPASS[c] && we && int'(waddr) == a) begin
            d = wdata;
            b = issue && int'(issue_rd) == a;
        end else begin
            d = m_regs[c][a];
            b = m_pend[c][a];
        end
    endfunction

    task automatic check_model();
        logic [31:0] d;
        logic        b;
        for (int c = 0; c < 2; c++) begin
            exp_read(c, int'(raddr1), d, b);
            chk($sformatf("cfg%0d_rdata1", c), rdata1_o[c], d);
            chk($sformatf("cfg%0d_busy1", c), 32'(busy1_o[c]), 32'(b));
            exp_read(c, int'(raddr2), d, b);
            chk($sformatf("cfg%0d_rdata2", c), rdata2_o[c], d);
            chk($sformatf("cfg%0d_busy2", c), 32'(busy2_o[c]), 32'(b));
            b = (CFG_ZERO[c] && issue_rd == '0) ? 1'b0 : m_pend[c][int'(issue_rd)];
            chk($sformatf("cfg%0d_busy_rd", c), 32'(busyrd_o[c]), 32'(b));
        end
    endtask

    task automatic drive(input bit r, input bit w, input int wa, input logic [31:0] wd,
                         input int ra1, input int ra2, input bit is, input int ird);
        @(negedge clk);
        rst      = r;
        we       = w;
        waddr    = regidx_t'(wa);
        wdata    = wd;
        raddr1   = regidx_t'(ra1);
        raddr2   = regidx_t'(ra2);
        issue    = is;
        issue_rd = regidx_t'(ird);
        #1;
        $display("txn rst=%0d we=%0d wa=%0d wd=%h ra1=%0d ra2=%0d iss=%0d ird=%0d | a:%h/%h b:%h/%h",
                 r, w, wa, wd, ra1, ra2, is, ird,
                 rdata1_o[0], rdata2_o[0], rdata1_o[1], rdata2_o[1]);
    endtask

    // Advance one edge and apply the same edge to the model.
    task automatic step();
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                for (int i = 0; i < 32; i++) begin
                    m_regs[c][i] = 32'h0;
                    m_pend[c][i] = 1'b0;
                end
            end else begin
                if (we && !(CFG_ZERO[c] && waddr == '0)) begin
                    m_regs[c][int'(waddr)] = wdata;
                    m_pend[c][int'(waddr)] = 1'b0;
                end
                if (issue && !(CFG_ZERO[c] && issue_rd == '0)) begin
                    m_pend[c][int'(issue_rd)] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[c][i] = 32'h0;
                m_pend[c][i] = 1'b0;
            end
        end

        // Reset, then sweep every index on both ports.
        drive(1, 0, 0, 0, 0, 0, 0, 0); step();
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 0, i, 31 - i, 0, i);
            check_model();
            chk("rst_rdata1", rdata1_o[0], 32'h0);
            chk("rst_busy1", 32'(busy1_o[0]), 32'h0);
            step();
        end

        // Write then read.
        drive(0, 1, 5, 32'hDEADBEEF, 1, 2, 0, 0); check_model(); step();
        drive(0, 0, 0, 0, 5, 5, 0, 0); check_model();
        chk("wr_rd_a", rdata1_o[0], 32'hDEADBEEF);
        chk("wr_rd_b", rdata1_o[1], 32'hDEADBEEF);
        step();

        // Forwarding versus the old value.
        drive(0, 1, 7, 32'h0000AAAA, 0, 0, 0, 0); check_model(); step();
        drive(0, 1, 7, 32'h00001234, 1, 7, 0, 0); check_model();
        chk("byp_rdata2", rdata2_o[0], 32'h00001234);
        chk("byp_busy2", 32'(busy2_o[0]), 32'h0);
        chk("nobyp_rdata2", rdata2_o[1], 32'h0000AAAA);
        step();

        // Register 0 ignores writes and issues.
        drive(0, 1, 0, 32'hFFFFFFFF, 0, 0, 1, 0); check_model();
        chk("r0_byp_rdata1", rdata1_o[0], 32'h0);
        chk("r0_byp_busy1", 32'(busy1_o[0]), 32'h0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); check_model();
        chk("r0_rdata1", rdata1_o[0], 32'h0);
        chk("r0_busy2", 32'(busy2_o[0]), 32'h0);
        chk("r0_busy_rd", 32'(busyrd_o[0]), 32'h0);
        chk("r0_ordinary", rdata1_o[1], 32'hFFFFFFFF);
        step();

        // Scoreboard set / clear / set-wins.
        drive(0, 0, 0, 0, 3, 0, 1, 3); check_model();
        chk("sb_not_yet", 32'(busy1_o[0]), 32'h0);
        step();
        drive(0, 0, 0, 0, 3, 0, 0, 3); check_model();
        chk("sb_set", 32'(busy1_o[0]), 32'h1);
        chk("sb_waw", 32'(busyrd_o[0]), 32'h1);
        step();
        drive(0, 1, 3, 32'h55, 3, 0, 0, 0); check_model();
        chk("sb_byp_clr", 32'(busy1_o[0]), 32'h0);
        chk("sb_nobyp_pend", 32'(busy1_o[1]), 32'h1);
        step();
        drive(0, 0, 0, 0, 3, 3, 0, 0); check_model();
        chk("sb_clr", 32'(busy1_o[0]), 32'h0);
        step();
        drive(0, 1, 3, 32'h66, 3, 0, 1, 3); check_model();
        chk("sb_byp_issue", 32'(busy1_o[0]), 32'h1);
        step();
        drive(0, 0, 0, 0, 3, 3, 0, 0); check_model();
        chk("sb_issue_wins", 32'(busy1_o[0]), 32'h1);
        chk("sb_issue_data", rdata1_o[0], 32'h66);
        step();

        // Reset mid-stream discards pending state.
        drive(0, 1, 9, 32'h99, 0, 0, 1, 4); check_model(); step();
        drive(0, 0, 0, 0, 4, 9, 1, 9); check_model();
        chk("mid_pend4", 32'(busy1_o[0]), 32'h1);
        step();
        drive(1, 1, 4, 32'h44, 4, 9, 1, 9); check_model(); step();
        drive(0, 0, 0, 0, 4, 9, 0, 9); check_model();
        chk("mid_busy1", 32'(busy1_o[0]), 32'h0);
        chk("mid_busy2", 32'(busy2_o[0]), 32'h0);
        chk("mid_rdata2", rdata2_o[0], 32'h0);
        chk("mid_rdata2_b", rdata2_o[1], 32'h0);
        step();

        // Random traffic with a narrow index range to force collisions.
        for (int n = 0; n < 600; n++) begin
            int a[4];
            for (int k = 0; k < 4; k++) begin
                a[k] = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 7))
                                                   : int'($urandom_range(0, 31));
            end
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, a[0], $urandom,
                  a[1], a[2], $urandom_range(0, 1) == 1, a[3]);
            check_model();
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register data width in bits.
REQ-002 Parameter NUM_REGS, default 32, SHALL set the register count; legal values are powers of two from 2 to 64.
REQ-003 Parameter ADDR_W, default $clog2(NUM_REGS), SHALL set the address width and SHALL NOT be overridden.
REQ-004 Parameter BYPASS, default 1, SHALL enable write-to-read forwarding when 1.
REQ-005 Parameter ZERO_REG, default 1, SHALL hard-wire register 0 to zero when 1.
REQ-006 clk  in  1  sole clock; all state changes on rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 we  in  1  writeback enable.
REQ-009 waddr  in  ADDR_W  writeback register index.
REQ-010 wdata  in  DATA_W  writeback data.
REQ-011 raddr1, raddr2  in  ADDR_W  read port indices.
REQ-012 rdata1, rdata2  out  DATA_W  read data, combinational.
REQ-013 issue  in  1  instruction issue; marks issue_rd pending.
REQ-014 issue_rd  in  ADDR_W  destination index of the issuing instruction.
REQ-015 busy1, busy2  out  1  pending-write flag for raddr1 and raddr2, combinational.
REQ-016 busy_rd  out  1  pending-write flag for issue_rd (WAW hazard), combinational.

Function
REQ-017 Storage SHALL be NUM_REGS x DATA_W registers plus one pending bit per register.
REQ-018 When we=1, regs[waddr] SHALL take wdata at the next rising edge.
REQ-019 When we=1, pending[waddr] SHALL clear at the same edge.
REQ-020 When issue=1, pending[issue_rd] SHALL set at the next rising edge.
REQ-021 When issue=1 and we=1 target the same index in one cycle, data SHALL be written and the pending bit SHALL end set (issue wins).
REQ-022 rdataN SHALL equal regs[raddrN] with zero cycles of latency.
REQ-023 With BYPASS=1, we=1 and raddrN==waddr, rdataN SHALL equal wdata in that cycle.
REQ-024 With BYPASS=1 under the condition of REQ-023, busyN SHALL read 0 in that cycle unless issue targets the same index.
REQ-025 Without bypass, busyN SHALL equal pending[raddrN] and busy_rd SHALL equal pending[issue_rd].
REQ-026 With ZERO_REG=1, writes to index 0 SHALL be ignored, pending[0] SHALL never set, and reads of index 0 SHALL return 0 with busy 0, bypass included.
REQ-027 With ZERO_REG=0, index 0 SHALL behave as an ordinary register.
REQ-028 Writeback with we=1 to a non-pending register SHALL be legal and SHALL write the data.
REQ-029 Issue to an already-pending register SHALL keep the bit set; the block SHALL NOT count multiple outstanding writes.
REQ-030 Both read ports on the same index SHALL return identical data and busy values.

Reset
REQ-031 rst=1 at a rising edge SHALL clear every register to 0 and every pending bit to 0.
REQ-032 rst SHALL take priority over we and issue in the same cycle.
REQ-033 Reset asserted mid-stream SHALL discard all outstanding pending state.
REQ-034 After reset, all rdata outputs SHALL read 0 and all busy outputs SHALL read 0.

Structure
REQ-035 A shared package SHALL hold the default DATA_W and NUM_REGS constants and a regidx_t address type.
REQ-036 The pending-bit array SHALL be a sub-module named regfile_scoreboard, with its own set, clear, lookup and rst ports; data storage SHALL remain in regfile_sb.

Verification
REQ-037 Reset: rst for 1 cycle, then read all 32 indices -> every rdata is 0 and every busy is 0.
REQ-038 Write and read: we=1, waddr=5, wdata=0xDEADBEEF; next cycle raddr1=5 -> rdata1=0xDEADBEEF.
REQ-039 Bypass: in the same cycle as we=1, waddr=7, wdata=0x1234, drive raddr2=7 -> rdata2=0x1234 and busy2=0; with BYPASS=0 -> the old value.
REQ-040 Register 0: we=1, waddr=0, wdata=0xFFFFFFFF, plus issue to index 0 -> rdata=0 and busy=0 on the following cycles.
REQ-041 Scoreboard: issue with issue_rd=3 -> busy1=1 for raddr1=3 from the next cycle; we=1 to index 3 -> busy1=0 after that edge; issue and we to index 3 in the same cycle -> busy1 stays 1.
REQ-042 Reset mid-op: issue to indices 4 and 9, then rst -> busy is 0 for both and data is 0 the following cycle.
